// File: rtl/i2c_gain_master.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_gain_master
//  Description : I2C master that writes or reads one register of the PID
//                gain-configuration target (K_p/K_i/K_d).
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_gain_master #(
    parameter int         CLK_DIV     = 8,
    parameter logic [6:0] DEVICE_ADDR = 7'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    input  logic       SCL_in,
    input  logic       SDA_in,
    output logic       SCL_out,
    output logic       SCL_ena,
    output logic       SDA_out,
    output logic       SDA_ena
);

    localparam int                 c_DIV_W    = $clog2(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_ADDR  = 4'd2,
        S_ACK1  = 4'd3,
        S_REG   = 4'd4,
        S_ACK2  = 4'd5,
        S_WDATA = 4'd6,
        S_RDATA = 4'd7,
        S_ACK3  = 4'd8,
        S_STOP  = 4'd9,
        S_DONE  = 4'd10
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_DIV_W-1:0]   r_div;
    logic [1:0]           r_quarter;
    logic [2:0]           r_bit;
    logic                 r_rw;
    logic [7:0]           r_reg_addr;
    logic [7:0]           r_wr_data;
    logic [7:0]           r_rx;
    logic [7:0]           r_rd_data;
    logic                 r_ack_error;

    logic                 w_accept;
    logic                 w_active;
    logic                 w_q_end;
    logic                 w_slot_end;
    logic                 w_sample;
    logic                 w_byte_state;
    logic                 w_ack_slot;
    logic [7:0]           w_tx_byte;
    logic [2:0]           w_bit_idx;
    logic                 w_scl_out;
    logic                 w_scl_ena;
    logic                 w_sda_out;
    logic                 w_sda_ena;
    logic                 w_unused;

    // SCL is never stretched by the target, so the bus level is not consulted.
    assign w_unused     = SCL_in;

    assign w_accept     = (r_state == S_IDLE) && start && ena;
    assign w_active     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_q_end      = (r_div == c_DIV_LAST);
    assign w_slot_end   = w_q_end && (r_quarter == 2'd3);
    assign w_sample     = w_q_end && (r_quarter == 2'd2);
    assign w_byte_state = (r_state == S_ADDR) || (r_state == S_REG) ||
                          (r_state == S_WDATA) || (r_state == S_RDATA);
    assign w_ack_slot   = (r_state == S_ACK1) || (r_state == S_ACK2) ||
                          ((r_state == S_ACK3) && r_rw);
    assign w_bit_idx    = 3'd7 - r_bit;

    always_comb begin
        case (r_state)
            S_ADDR:  w_tx_byte = {DEVICE_ADDR, r_rw};
            S_REG:   w_tx_byte = r_reg_addr;
            default: w_tx_byte = r_wr_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_quarter   <= 2'd0;
            r_bit       <= 3'd0;
            r_rw        <= 1'b0;
            r_reg_addr  <= 8'h00;
            r_wr_data   <= 8'h00;
            r_rx        <= 8'h00;
            r_rd_data   <= 8'h00;
            r_ack_error <= 1'b0;
        end else if (w_accept) begin
            r_div       <= '0;
            r_quarter   <= 2'd0;
            r_bit       <= 3'd0;
            r_rw        <= rw;
            r_reg_addr  <= reg_addr;
            r_wr_data   <= wr_data;
            r_ack_error <= 1'b0;
        end else if (w_active) begin
            if (w_q_end) begin
                r_div     <= '0;
                r_quarter <= r_quarter + 2'd1;
            end else begin
                r_div <= r_div + c_DIV_ONE;
            end
            if (w_slot_end) begin
                r_bit <= (w_byte_state && (r_bit != 3'd7)) ? r_bit + 3'd1 : 3'd0;
            end
            if (w_sample && w_ack_slot && SDA_in) begin
                r_ack_error <= 1'b1;
            end
            if (w_sample && (r_state == S_RDATA)) begin
                r_rx <= {r_rx[6:0], SDA_in};
            end
            // Publish only the complete byte so the host never sees a partial shift.
            if (w_slot_end && (r_state == S_RDATA) && (r_bit == 3'd7)) begin
                r_rd_data <= r_rx;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_scl_out    = 1'b1;
        w_scl_ena    = 1'b0;
        w_sda_out    = 1'b1;
        w_sda_ena    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_START;
            end
            S_START: begin
                w_scl_ena = 1'b1;
                w_sda_ena = 1'b1;
                w_sda_out = ~r_quarter[1];
                if (w_slot_end) w_next_state = S_ADDR;
            end
            S_ADDR, S_REG, S_WDATA: begin
                w_scl_ena = 1'b1;
                w_scl_out = r_quarter[1];
                w_sda_ena = 1'b1;
                w_sda_out = w_tx_byte[w_bit_idx];
                if (w_slot_end && (r_bit == 3'd7)) begin
                    case (r_state)
                        S_ADDR:  w_next_state = S_ACK1;
                        S_REG:   w_next_state = S_ACK2;
                        default: w_next_state = S_ACK3;
                    endcase
                end
            end
            S_RDATA: begin
                w_scl_ena = 1'b1;
                w_scl_out = r_quarter[1];
                if (w_slot_end && (r_bit == 3'd7)) w_next_state = S_ACK3;
            end
            S_ACK1: begin
                w_scl_ena = 1'b1;
                w_scl_out = r_quarter[1];
                if (w_slot_end) w_next_state = r_ack_error ? S_STOP : S_REG;
            end
            S_ACK2: begin
                w_scl_ena = 1'b1;
                w_scl_out = r_quarter[1];
                if (w_slot_end) begin
                    if (r_ack_error) w_next_state = S_STOP;
                    else             w_next_state = r_rw ? S_WDATA : S_RDATA;
                end
            end
            S_ACK3: begin
                w_scl_ena = 1'b1;
                w_scl_out = r_quarter[1];
                // On a read the master NACKs the last byte to end the transfer.
                if (!r_rw) begin
                    w_sda_ena = 1'b1;
                    w_sda_out = 1'b1;
                end
                if (w_slot_end) w_next_state = S_STOP;
            end
            S_STOP: begin
                w_scl_ena = 1'b1;
                w_scl_out = (r_quarter != 2'd0);
                w_sda_ena = 1'b1;
                w_sda_out = r_quarter[1];
                if (w_slot_end) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign rd_data   = r_rd_data;
    assign busy      = w_active;
    assign done      = (r_state == S_DONE);
    assign ack_error = r_ack_error;
    assign SCL_out   = w_scl_out;
    assign SCL_ena   = w_scl_ena;
    assign SDA_out   = w_sda_out;
    assign SDA_ena   = w_sda_ena;

endmodule
`default_nettype wire

// File: tb/tb_i2c_gain_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_gain_master
//  Description : Directed bench with a slot-level SDA scoreboard and a simple
//                I2C target model, run at CLK_DIV=8 and CLK_DIV=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_gain_master;

    logic       clk = 1'b0;
    logic       rst, ena, start, rw, sel, tgt_sda;
    logic [7:0] reg_addr, wr_data;

    logic [7:0] rd_data_a, rd_data_b;
    logic       busy_a, done_a, ack_error_a, scl_out_a, scl_ena_a, sda_out_a, sda_ena_a;
    logic       busy_b, done_b, ack_error_b, scl_out_b, scl_ena_b, sda_out_b, sda_ena_b;
    logic       start_a, start_b, sda_bus, scl_bus;
    logic [7:0] m_rd_data;
    logic       m_busy, m_done, m_ack_error, m_scl_out, m_scl_ena, m_sda_out, m_sda_ena;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic val;
        logic ena;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign start_a     = start & ~sel;
    assign start_b     = start & sel;
    assign m_rd_data   = sel ? rd_data_b   : rd_data_a;
    assign m_busy      = sel ? busy_b      : busy_a;
    assign m_done      = sel ? done_b      : done_a;
    assign m_ack_error = sel ? ack_error_b : ack_error_a;
    assign m_scl_out   = sel ? scl_out_b   : scl_out_a;
    assign m_scl_ena   = sel ? scl_ena_b   : scl_ena_a;
    assign m_sda_out   = sel ? sda_out_b   : sda_out_a;
    assign m_sda_ena   = sel ? sda_ena_b   : sda_ena_a;
    assign sda_bus     = (m_sda_ena ? m_sda_out : 1'b1) & tgt_sda;
    assign scl_bus     = m_scl_ena ? m_scl_out : 1'b1;

    i2c_gain_master #(.CLK_DIV(8)) u_dut_a (
        .clk(clk), .rst(rst), .ena(ena), .start(start_a), .rw(rw),
        .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data_a),
        .busy(busy_a), .done(done_a), .ack_error(ack_error_a),
        .SCL_in(scl_bus), .SDA_in(sda_bus),
        .SCL_out(scl_out_a), .SCL_ena(scl_ena_a),
        .SDA_out(sda_out_a), .SDA_ena(sda_ena_a)
    );

    i2c_gain_master #(.CLK_DIV(2)) u_dut_b (
        .clk(clk), .rst(rst), .ena(ena), .start(start_b), .rw(rw),
        .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data_b),
        .busy(busy_b), .done(done_b), .ack_error(ack_error_b),
        .SCL_in(scl_bus), .SDA_in(sda_bus),
        .SCL_out(scl_out_b), .SCL_ena(scl_ena_b),
        .SDA_out(sda_out_b), .SDA_ena(sda_ena_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected bus SDA at Q2 of each slot plus whether the master drives it.
    task automatic push_frame(input logic f_rw, input logic [7:0] ra, input logic [7:0] wd,
                              input logic [7:0] rdv, input bit nack_addr);
        logic [7:0] ab;
        ab = {7'h3F, f_rw};
        sb.push_back('{val: 1'b0, ena: 1'b1});
        for (int i = 0; i < 8; i++) sb.push_back('{val: ab[7-i], ena: 1'b1});
        sb.push_back('{val: nack_addr, ena: 1'b0});
        if (!nack_addr) begin
            for (int i = 0; i < 8; i++) sb.push_back('{val: ra[7-i], ena: 1'b1});
            sb.push_back('{val: 1'b0, ena: 1'b0});
            for (int i = 0; i < 8; i++)
                sb.push_back(f_rw ? '{val: wd[7-i], ena: 1'b1} : '{val: rdv[7-i], ena: 1'b0});
            sb.push_back(f_rw ? '{val: 1'b0, ena: 1'b0} : '{val: 1'b1, ena: 1'b1});
        end
        sb.push_back('{val: 1'b1, ena: 1'b1});
    endtask

    function automatic logic tgt_for(input int slot, input logic f_rw,
                                     input logic [7:0] rdv, input bit nack_addr);
        if (nack_addr)                return 1'b1;
        if (slot == 9 || slot == 18)  return 1'b0;
        if (slot >= 19 && slot <= 26) return f_rw ? 1'b1 : rdv[26-slot];
        if (slot == 27)               return f_rw ? 1'b0 : 1'b1;
        return 1'b1;
    endfunction

    task automatic run_frame(input string tag, input bit s_sel, input logic f_rw,
                             input logic [7:0] ra, input logic [7:0] wd, input logic [7:0] rdv,
                             input bit nack_addr, input int abort_slot, input bit mid_start);
        int div, slot_len, exp_slots, c, slot, q, d, scl_bad, rd_bad;
        bit seen_done;
        logic exp_scl;
        logic [7:0] rd_before;
        exp_t e;
        div       = s_sel ? 2 : 8;
        slot_len  = 4 * div;
        exp_slots = nack_addr ? 11 : 29;
        scl_bad   = 0;
        rd_bad    = 0;
        seen_done = 1'b0;
        sel       = s_sel;
        push_frame(f_rw, ra, wd, rdv, nack_addr);
        @(negedge clk);
        rw = f_rw; reg_addr = ra; wr_data = wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_rise"}, m_busy, 1'b1);
        rd_before = m_rd_data;
        for (c = 0; c < 4000; c++) begin
            slot = c / slot_len;
            q    = (c / div) % 4;
            d    = c % div;
            if (m_done) begin
                seen_done = 1'b1;
                break;
            end
            if (slot == abort_slot) begin
                rst = 1'b1;
                @(negedge clk);
                check({tag, "_abort_busy"}, m_busy, 1'b0);
                check({tag, "_abort_lines"}, {m_scl_ena, m_sda_ena}, 2'b00);
                check({tag, "_abort_rd_data"}, m_rd_data, 8'h00);
                rst = 1'b0;
                sb.delete();
                return;
            end
            start   = mid_start && (slot == 12) && (c % slot_len == 0);
            if (start) begin
                reg_addr = ra ^ 8'hFF;
                wr_data  = wd ^ 8'h55;
            end
            tgt_sda = tgt_for(slot, f_rw, rdv, nack_addr);
            #1;
            if (slot == 0)                  exp_scl = 1'b1;
            else if (slot == exp_slots - 1) exp_scl = (q != 0);
            else                            exp_scl = (q >= 2);
            if (m_scl_out !== exp_scl || m_scl_ena !== 1'b1) scl_bad++;
            if (slot <= 26 && m_rd_data !== rd_before) rd_bad++;
            if (q == 2 && d == div - 1) begin
                if (sb.size() == 0) begin
                    check($sformatf("%s_slot%0d_extra", tag, slot), 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("%s_slot%0d_sda", tag, slot), {sda_bus, m_sda_ena}, {e.val, e.ena});
                end
            end
            @(negedge clk);
        end
        start   = 1'b0;
        tgt_sda = 1'b1;
        check({tag, "_done_seen"}, seen_done, 1'b1);
        check({tag, "_length"}, c, exp_slots * slot_len);
        check({tag, "_busy_at_done"}, m_busy, 1'b0);
        check({tag, "_ack_error"}, m_ack_error, nack_addr);
        if (!f_rw && !nack_addr) check({tag, "_rd_data"}, m_rd_data, rdv);
        check({tag, "_scl_shape"}, scl_bad, 0);
        check({tag, "_rd_stable"}, rd_bad, 0);
        check({tag, "_sb_empty"}, sb.size(), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {m_done, m_scl_ena, m_sda_ena}, 3'b000);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; start = 1'b0; rw = 1'b0; sel = 1'b0;
        reg_addr = 8'h00; wr_data = 8'h00; tgt_sda = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rd_data", rd_data_a, 8'h00);
        check("reset_flags", {busy_a, done_a, ack_error_a}, 3'b000);
        check("reset_lines", {scl_out_a, sda_out_a, scl_ena_a, sda_ena_a}, 4'b1100);
        rst = 1'b0;
        @(negedge clk);

        run_frame("wr_kp",    1'b0, 1'b1, 8'h40, 8'h1E, 8'h00, 1'b0, -1, 1'b0);
        run_frame("rd_kd",    1'b0, 1'b0, 8'h42, 8'h00, 8'h2A, 1'b0, -1, 1'b0);
        run_frame("nack",     1'b0, 1'b1, 8'h40, 8'h33, 8'h00, 1'b1, -1, 1'b0);
        run_frame("wr_clear", 1'b0, 1'b1, 8'h41, 8'h5A, 8'h00, 1'b0, -1, 1'b0);
        run_frame("wr_mid",   1'b0, 1'b1, 8'h41, 8'hC3, 8'h00, 1'b0, -1, 1'b1);

        ena = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check("ena_low_busy", m_busy, 1'b0);
        ena = 1'b1;

        run_frame("rd_abort", 1'b0, 1'b0, 8'h40, 8'h00, 8'h99, 1'b0, 13, 1'b0);
        run_frame("wr_after", 1'b0, 1'b1, 8'h42, 8'h07, 8'h00, 1'b0, -1, 1'b0);
        run_frame("div2_wr",  1'b1, 1'b1, 8'h41, 8'hFF, 8'h00, 1'b0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_gain_master.md
Name: i2c_gain_master

Overview:
I2C controller that initiates single-register write and read transactions to the PID gain-configuration target, which holds the K_p, K_i and K_d registers. It generates SCL from the system clock and serialises the frame START, device address, R/W, ACK, register address, ACK, data, ACK/NACK, STOP. It sits at the bench/host side of the I2C bus and is the initiating end of the same frame format the target decodes.

Parameters:
CLK_DIV, 8, clk cycles per SCL quarter-period; minimum 2.
DEVICE_ADDR, 7'h3F, 7-bit target address sent in every frame.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
ena  input  1  block enable; gates acceptance of new requests only
start  input  1  one-cycle request pulse
rw  input  1  1 = write, 0 = read (the protocol's R/W encoding)
reg_addr  input  8  target register address (K_p=8'h40, K_i=8'h41, K_d=8'h42)
wr_data  input  8  write payload
rd_data  output  8  last byte read
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at transaction end
ack_error  output  1  target NACKed address, register or write data
SCL_in  input  1  bus SCL level (unused except debug; no clock stretching)
SDA_in  input  1  bus SDA level
SCL_out  output  1  SCL drive value
SCL_ena  output  1  SCL drive enable (0 = released)
SDA_out  output  1  SDA drive value
SDA_ena  output  1  SDA drive enable (0 = released)

Behaviour:
- Reset: rd_data=0, busy=0, done=0, ack_error=0, SCL_out=1, SDA_out=1, SCL_ena=0, SDA_ena=0. State is IDLE.
- Reset mid-transaction aborts on the next edge to IDLE with the reset values above. No STOP is generated.
- Accept: in IDLE with start=1 and ena=1:
  - latch rw, reg_addr and wr_data;
  - clear ack_error;
  - set busy the next cycle.
- start is ignored while busy or when ena=0. ena falling mid-transaction does not abort.
- Timing: each bit slot is 4 quarters (Q0–Q3), and each quarter lasts CLK_DIV clk cycles.
- Data slots: SCL=0 in Q0/Q1 and SCL=1 in Q2/Q3. SDA changes only at Q0 entry.
- SCL_ena=1 throughout busy.
- States, in order:
  - IDLE.
  - START slot: SCL=1 all quarters; SDA=1 in Q0/Q1, SDA=0 in Q2/Q3.
  - ADDR: 8 slots, {DEVICE_ADDR, rw}, MSB first.
  - ACK1.
  - REG: 8 slots, reg_addr, MSB first.
  - ACK2.
  - WDATA or RDATA: 8 slots.
  - ACK3.
  - STOP slot: Q0 SCL=0/SDA=0; Q1 SCL=1/SDA=0; Q2/Q3 SCL=1/SDA=1.
  - DONE: 1 cycle; done=1; busy drops; lines released.
- ACK1/ACK2 (and ACK3 after a write):
  - SDA_ena=0;
  - sample SDA_in on the last clk of Q2;
  - 0 = ACK, continue;
  - 1 = NACK: set ack_error and go directly to STOP.
- RDATA:
  - SDA_ena=0;
  - shift SDA_in MSB-first, sampled on the last clk of Q2;
  - rd_data updates once at the end of the 8th slot (never shows partial bytes).
- ACK3 on a read: master drives SDA=1 (NACK, end of read).
- Length: a full frame is 29 slots, i.e. 29*4*CLK_DIV clk cycles. With the default CLK_DIV this is 928 cycles from busy rising to the DONE cycle.
- NACK at ACK1 gives 11 slots total (START, 8 ADDR, ACK1, STOP).
- Driven bits use SDA_ena=1 with SDA_out equal to the bit value.

Test Plan:
- Write: rw=1, reg_addr=8'h40, wr_data=8'h1E, target model ACKs all. SDA at each Q2 must equal 0,0111111,1,0,01000000,0,00011110,(released),STOP. done pulses 928 cycles after busy rises; ack_error=0.
- Read: rw=0, reg_addr=8'h42, model returns 8'h2A. Required: rd_data=8'h2A at done, master NACK driven in ACK3, rd_data unchanged during the shift.
- Address NACK: model holds SDA high in ACK1. Required: ack_error=1, STOP follows immediately, done at 11*32 cycles. A following good write clears ack_error.
- start pulsed mid-frame with different reg_addr/wr_data → ignored, frame bits unchanged. start with ena=0 in IDLE → busy stays 0.
- rst asserted during REG slot 3 → next cycle busy=0, SCL_ena=0, SDA_ena=0, rd_data=0. A new write then completes normally.
- CLK_DIV=2: write 8'hFF to 8'h41 → 232-cycle frame, SCL high/low each 4 cycles, bits correct.
